// File: rtl/fifo_rd_stream.sv
// Read-side drain controller for syn_fifo. It pops FIFO words into a 2-entry skid buffer that
// covers the FIFO's one-cycle read latency, and presents them as a valid/ready stream with packet framing.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  words_out
);
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] PKT_MAX = PW'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] skid [2];
  logic [PW-1:0]         pkt_cnt;
  logic [1:0]            pend;
  logic                  pop_out;

  // Words already committed to the buffer: stored plus the one returning from the FIFO.
  assign pend    = occ + {1'b0, inflight};
  assign pop_out = out_valid && out_ready;

  assign fifo_rd_en = !rst && en && !fifo_empty &&
                      ((pend < 2'd2) || ((pend == 2'd2) && pop_out));
  assign fifo_rd_cs = fifo_rd_en;

  assign out_valid = (occ != 2'd0);
  assign out_data  = skid[head];
  assign out_last  = out_valid && (pkt_cnt == PKT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      pkt_cnt   <= '0;
      words_out <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) tail <= ~tail;
      if (pop_out)  head <= ~head;
      case ({inflight, pop_out})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop_out) begin
        pkt_cnt   <= (pkt_cnt == PKT_MAX) ? '0 : pkt_cnt + PW'(1);
        words_out <= words_out + CNT_WIDTH'(1);
      end
    end
  end

  // Buffer storage carries no reset; a word returning during reset is dropped.
  always_ff @(posedge clk) begin
    if (inflight && !rst) skid[tail] <= fifo_data;
  end

  // A capture into a full buffer without a simultaneous pop would lose data.
  assert property (@(posedge clk) disable iff (rst)
    !((occ == 2'd2) && inflight && !pop_out));
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (PKT_LEN 4 / CNT_WIDTH 16 and PKT_LEN 1 / CNT_WIDTH 4)
// fed from behavioural FIFOs and checked every cycle against an in-order word-flow model.
module tb_fifo_rd_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;
  logic       push_req = 1'b0;
  logic [7:0] push_val = 8'd0;
  logic       chk_on = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int PL = (g == 0) ? 4 : 1;
    localparam int CW = (g == 0) ? 16 : 4;
    logic          fe;
    logic          rd_en;
    logic          rd_cs;
    logic          ov;
    logic          ol;
    logic [7:0]    fd;
    logic [7:0]    od;
    logic [CW-1:0] wo;

    fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fe), .fifo_data(fd),
      .fifo_rd_cs(rd_cs), .fifo_rd_en(rd_en), .out_valid(ov), .out_ready(out_ready),
      .out_data(od), .out_last(ol), .words_out(wo));

    logic [7:0] fq[$];
    logic [7:0] pdata[$];
    int         pcyc[$];
    int         cyc = 0;
    int         dcnt = 0;

    initial begin
      logic       s_rst, s_pop, s_acc, s_push;
      logic [7:0] s_val;
      logic       ev, el, erd;
      logic [7:0] ed;
      int         held;
      fe = 1'b1;
      fd = 8'd0;
      forever begin
        @(negedge clk);
        s_rst  = rst;
        s_pop  = rd_en;
        s_push = push_req;
        s_val  = push_val;
        held   = pdata.size();
        ev = 1'b0;
        ed = 8'd0;
        if (held > 0) begin
          ev = (cyc >= pcyc[0] + 2);
          ed = pdata[0];
        end
        el    = ev && ((dcnt % PL) == PL - 1);
        s_acc = ev && out_ready;
        erd   = !rst && en && !fe && ((held - (s_acc ? 1 : 0)) < 2);
        if (chk_on) begin
          chk($sformatf("lane%0d_valid", g), 32'(ov), 32'(ev));
          if (ev) chk($sformatf("lane%0d_data", g), 32'(od), 32'(ed));
          chk($sformatf("lane%0d_last", g), 32'(ol), 32'(el));
          chk($sformatf("lane%0d_words_out", g), 32'(wo), 32'(dcnt % (1 << CW)));
          chk($sformatf("lane%0d_rd_en", g), 32'(rd_en), 32'(erd));
          chk($sformatf("lane%0d_rd_cs", g), 32'(rd_cs), 32'(erd));
          chk($sformatf("lane%0d_held_le2", g), 32'(held <= 2), 32'd1);
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
          if (fq.size() == 0) begin
            chk($sformatf("lane%0d_pop_on_empty", g), 32'd1, 32'd0);
            fd = 8'($urandom);
          end else begin
            fd = fq.pop_front();
          end
        end else begin
          fd = 8'($urandom);
        end
        if (s_push) fq.push_back(s_val);
        if (s_rst) begin
          pdata.delete();
          pcyc.delete();
          dcnt = 0;
        end else begin
          if (s_acc) begin
            void'(pdata.pop_front());
            void'(pcyc.pop_front());
            dcnt++;
          end
          if (s_pop) begin
            pdata.push_back(fd);
            pcyc.push_back(cyc);
          end
        end
        fe = (fq.size() == 0);
        cyc++;
      end
    end
  end

  int         stp, acc_n, pop_n, last1_n;
  int         first_pop_stp, first_v_stp, first_acc_stp, last_acc_stp;
  logic [7:0] first_acc;
  logic [15:0] last_mask;

  task automatic clr();
    stp = 0; acc_n = 0; pop_n = 0; last1_n = 0;
    first_pop_stp = -1; first_v_stp = -1; first_acc_stp = -1; last_acc_stp = -1;
    first_acc = 8'd0; last_mask = 16'd0;
  endtask

  task automatic step(input logic r, input logic e, input logic rdy, input logic p,
                      input logic [7:0] v);
    rst = r; en = e; out_ready = rdy; push_req = p; push_val = v;
    #1;
    if (lane[0].rd_en) begin
      pop_n++;
      if (first_pop_stp < 0) first_pop_stp = stp;
    end
    if (lane[0].ov && first_v_stp < 0) first_v_stp = stp;
    if (lane[0].ov && rdy) begin
      if (acc_n == 0) begin
        first_acc = lane[0].od;
        first_acc_stp = stp;
      end
      last_acc_stp = stp;
      if (lane[0].ol && lane[0].od < 8'd16) last_mask[lane[0].od[3:0]] = 1'b1;
      acc_n++;
    end
    if (lane[1].ov && rdy && lane[1].ol) last1_n++;
    stp++;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int pushed;
    logic p, rdy;
    clr();
    @(posedge clk);
    #2;
    chk_on = 1'b1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_valid", 32'(lane[0].ov), 32'd0);
    chk("reset_last", 32'(lane[0].ol), 32'd0);
    chk("reset_words0", 32'(lane[0].wo), 32'd0);
    chk("reset_words1", 32'(lane[1].wo), 32'd0);

    // Eight words streamed straight through.
    clr();
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 8'(i));
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    chk("t1_latency", 32'(first_v_stp - first_pop_stp), 32'd2);
    chk("t1_count", 32'(acc_n), 32'd8);
    chk("t1_back_to_back", 32'(last_acc_stp - first_acc_stp), 32'd7);
    chk("t1_last_words", 32'(last_mask), 32'h0088);
    chk("t1_words_out", 32'(lane[0].wo), 32'd8);
    chk("t1_fifo_empty", 32'(lane[0].fe), 32'd1);

    // Prefilled FIFO held off by the consumer.
    clr();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 8'(100 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    chk("t2_stall_pops", 32'(pop_n), 32'd2);
    chk("t2_hold_valid", 32'(lane[0].ov), 32'd1);
    chk("t2_hold_data", 32'(lane[0].od), 32'd100);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0);
    chk("t2_count", 32'(acc_n), 32'd6);
    chk("t2_first", 32'(first_acc), 32'd100);

    // Random backpressure and arrivals.
    clr();
    pushed = 0;
    for (int i = 0; i < 3000 && acc_n < 200; i++) begin
      p = (pushed < 200) && ($urandom_range(3) != 0);
      rdy = $urandom_range(1) == 1;
      step(0, 1, rdy, p, 8'($urandom));
      if (p) pushed++;
    end
    chk("t3_count", 32'(acc_n), 32'd200);

    // Enable dropped right after two pops.
    clr();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 8'(50 + i));
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    chk("t4_pops_en_low", 32'(pop_n), 32'd2);
    chk("t4_drained", 32'(acc_n), 32'd2);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    chk("t4_count", 32'(acc_n), 32'd5);
    chk("t4_fifo_empty", 32'(lane[0].fe), 32'd1);

    // Reset with one word buffered and one returning.
    clr();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 8'(200 + i));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("t5_valid_after_rst", 32'(lane[0].ov), 32'd0);
    chk("t5_words_after_rst", 32'(lane[0].wo), 32'd0);
    clr();
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    chk("t5_count", 32'(acc_n), 32'd3);
    chk("t5_next_word", 32'(first_acc), 32'd203);

    // Twenty words: PKT_LEN 1 flags every word and the 4-bit count wraps.
    step(1, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 8'(i));
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
    chk("t6_count", 32'(acc_n), 32'd20);
    chk("t6_lasts_pkt1", 32'(last1_n), 32'd20);
    chk("t6_words_wrap", 32'(lane[1].wo), 32'd4);
    chk("t6_words_full", 32'(lane[0].wo), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
